// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Opcode map and register-field positions follow RV32I.
package pipe_hazard_ctrl_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;

    typedef enum logic [0:0] {
        HZ_ST_RUN      = 1'b0,
        HZ_ST_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
    } rs_use_t;

    function automatic logic [4:0] rs1_of(input logic [INSTR_WIDTH-1:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [INSTR_WIDTH-1:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_rs_use.sv
// Opcode to source-register usage; shared with the forwarding unit.
module hz_rs_use
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output rs_use_t    rs_use
);

    always_comb begin
        rs_use = '0;
        case (opcode)
            OP_JALR,
            OP_LOAD,
            OP_IMM:    rs_use.uses_rs1 = 1'b1;
            OP_BRANCH,
            OP_STORE,
            OP_R: begin
                rs_use.uses_rs1 = 1'b1;
                rs_use.uses_rs2 = 1'b1;
            end
            default:   rs_use = '0;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencing: memory freeze, EX redirect,
// load-use interlock and fetch wait, plus a stall performance counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_WIDTH-1:0] instr_id,
    input  logic                   id_valid,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_valid,
    input  logic                   redirect_ex,
    input  logic                   mem_op_mem,
    input  logic                   dmem_ack,
    input  logic                   imem_ready,
    output logic                   pc_we,
    output logic                   if_id_we,
    output logic                   if_id_flush,
    output logic                   id_ex_we,
    output logic                   id_ex_flush,
    output logic                   ex_mem_we,
    output logic                   mem_wb_flush,
    output logic                   dmem_req,
    output logic                   dmem_timeout,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WAIT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_WAIT - 1);

    hz_state_e       state;
    hz_state_e       state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_nxt;
    rs_use_t         rs_use;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            load_use;
    logic            mem_active;
    logic            freeze;
    logic            unused_bits;

    hz_rs_use u_rs_use (
        .opcode (instr_id[6:0]),
        .rs_use (rs_use)
    );

    assign unused_bits = ^{instr_id[INSTR_WIDTH-1:25], instr_id[14:7]};

    assign rs1_hit  = rs_use.uses_rs1 & (rs1_of(instr_id) == ex_rd);
    assign rs2_hit  = rs_use.uses_rs2 & (rs2_of(instr_id) == ex_rd);
    assign load_use = id_valid & ex_valid & ex_mem_read
                    & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    assign mem_active = (state == HZ_ST_MEM_WAIT) | mem_op_mem;
    assign freeze     = mem_active & ~dmem_ack;

    // Outputs are forced to their reset values while rst_n is low so
    // the request drops immediately, not at the next edge.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b1;
        mem_wb_flush = 1'b0;
        dmem_req     = 1'b0;
        dmem_timeout = 1'b0;
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        if (rst_n) begin
            dmem_req = mem_active;
            case (state)
                HZ_ST_RUN: begin
                    if (mem_op_mem && !dmem_ack) begin
                        state_nxt = HZ_ST_MEM_WAIT;
                        wait_nxt  = WC_W'(1);
                    end
                end
                HZ_ST_MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_nxt = HZ_ST_RUN;
                        wait_nxt  = '0;
                    end else begin
                        dmem_timeout = (wait_cnt == WC_LAST);
                        if (wait_cnt != WC_MAX)
                            wait_nxt = wait_cnt + 1'b1;
                    end
                end
                default: state_nxt = HZ_ST_RUN;
            endcase
            if (freeze) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_we     = 1'b0;
                ex_mem_we    = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (redirect_ex) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HZ_ST_RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (!pc_we && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: two instances (default and MAX_WAIT=4/CNT_W=4)
// driven by the same stimulus.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_id;
    logic        id_valid;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_valid;
    logic        redirect_ex;
    logic        mem_op_mem;
    logic        dmem_ack;
    logic        imem_ready;

    logic        a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_we;
    logic        a_id_ex_flush, a_ex_mem_we, a_mem_wb_flush;
    logic        a_dmem_req, a_dmem_timeout;
    logic [31:0] a_stall_cnt;

    logic        b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_we;
    logic        b_id_ex_flush, b_ex_mem_we, b_mem_wb_flush;
    logic        b_dmem_req, b_dmem_timeout;
    logic [3:0]  b_stall_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] ADD_X5_X7 = 32'h00728333;
    localparam logic [31:0] ADD_X7_X5 = 32'h00538333;
    localparam logic [31:0] ADD_X0_X7 = 32'h00700333;
    localparam logic [31:0] LUI_X5    = 32'h005282B7;
    localparam logic [31:0] ADDI_X7_5 = 32'h00538313;

    // {pc_we,if_id_we,if_id_flush,id_ex_we,id_ex_flush,
    //  ex_mem_we,mem_wb_flush,dmem_req,dmem_timeout}
    localparam logic [8:0] P_FREE = 9'b110101000;
    localparam logic [8:0] P_LU   = 9'b000111000;
    localparam logic [8:0] P_RDIR = 9'b111111000;
    localparam logic [8:0] P_IMEM = 9'b011101000;
    localparam logic [8:0] P_FRZ  = 9'b000000110;
    localparam logic [8:0] P_TO   = 9'b000000111;
    localparam logic [8:0] P_REL  = 9'b110101010;
    localparam logic [8:0] P_RREL = 9'b111111010;

    pipe_hazard_ctrl dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_id     (instr_id),
        .id_valid     (id_valid),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_valid     (ex_valid),
        .redirect_ex  (redirect_ex),
        .mem_op_mem   (mem_op_mem),
        .dmem_ack     (dmem_ack),
        .imem_ready   (imem_ready),
        .pc_we        (a_pc_we),
        .if_id_we     (a_if_id_we),
        .if_id_flush  (a_if_id_flush),
        .id_ex_we     (a_id_ex_we),
        .id_ex_flush  (a_id_ex_flush),
        .ex_mem_we    (a_ex_mem_we),
        .mem_wb_flush (a_mem_wb_flush),
        .dmem_req     (a_dmem_req),
        .dmem_timeout (a_dmem_timeout),
        .stall_cnt    (a_stall_cnt)
    );

    pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_id     (instr_id),
        .id_valid     (id_valid),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_valid     (ex_valid),
        .redirect_ex  (redirect_ex),
        .mem_op_mem   (mem_op_mem),
        .dmem_ack     (dmem_ack),
        .imem_ready   (imem_ready),
        .pc_we        (b_pc_we),
        .if_id_we     (b_if_id_we),
        .if_id_flush  (b_if_id_flush),
        .id_ex_we     (b_id_ex_we),
        .id_ex_flush  (b_id_ex_flush),
        .ex_mem_we    (b_ex_mem_we),
        .mem_wb_flush (b_mem_wb_flush),
        .dmem_req     (b_dmem_req),
        .dmem_timeout (b_dmem_timeout),
        .stall_cnt    (b_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pat_a();
        return {a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_we,
                a_id_ex_flush, a_ex_mem_we, a_mem_wb_flush,
                a_dmem_req, a_dmem_timeout};
    endfunction

    function automatic logic [8:0] pat_b();
        return {b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_we,
                b_id_ex_flush, b_ex_mem_we, b_mem_wb_flush,
                b_dmem_req, b_dmem_timeout};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        instr_id    = NOP;
        id_valid    = 1'b0;
        ex_rd       = 5'd0;
        ex_mem_read = 1'b0;
        ex_valid    = 1'b0;
        redirect_ex = 1'b0;
        mem_op_mem  = 1'b0;
        dmem_ack    = 1'b0;
        imem_ready  = 1'b1;
    endtask

    task automatic lu_setup(input logic [31:0] instr, input logic [4:0] rd);
        instr_id    = instr;
        id_valid    = 1'b1;
        ex_rd       = rd;
        ex_mem_read = 1'b1;
        ex_valid    = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #1;
        chk("reset_pat", 32'(pat_a()), 32'(P_FREE));
        chk("reset_cnt", a_stall_cnt, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("run_free", 32'(pat_a()), 32'(P_FREE));

        // load-use on rs1
        @(negedge clk); idle(); lu_setup(ADD_X5_X7, 5'd5); #1;
        chk("lu_rs1", 32'(pat_a()), 32'(P_LU));
        @(negedge clk); idle(); instr_id = ADD_X5_X7; id_valid = 1'b1; #1;
        chk("lu_after", 32'(pat_a()), 32'(P_FREE));
        chk("lu_cnt", a_stall_cnt, 32'd1);

        @(negedge clk); idle(); lu_setup(ADD_X0_X7, 5'd0); #1;
        chk("lu_x0", 32'(pat_a()), 32'(P_FREE));
        @(negedge clk); idle(); lu_setup(LUI_X5, 5'd5); #1;
        chk("lu_lui", 32'(pat_a()), 32'(P_FREE));
        @(negedge clk); idle(); lu_setup(ADD_X7_X5, 5'd5); #1;
        chk("lu_rs2", 32'(pat_a()), 32'(P_LU));
        @(negedge clk); idle(); lu_setup(ADDI_X7_5, 5'd5); #1;
        chk("lu_imm_rs2", 32'(pat_a()), 32'(P_FREE));
        @(negedge clk); idle(); lu_setup(ADD_X5_X7, 5'd5); id_valid = 1'b0; #1;
        chk("lu_id_inval", 32'(pat_a()), 32'(P_FREE));

        @(negedge clk); idle(); lu_setup(ADD_X5_X7, 5'd5); redirect_ex = 1'b1; #1;
        chk("rdir_lu", 32'(pat_a()), 32'(P_RDIR));
        @(negedge clk); idle(); imem_ready = 1'b0; #1;
        chk("imem_wait", 32'(pat_a()), 32'(P_IMEM));
        @(negedge clk); idle(); #1;
        chk("cnt_3", a_stall_cnt, 32'd3);

        // data memory wait: ack on the 4th cycle
        @(negedge clk); idle(); mem_op_mem = 1'b1; #1;
        chk("mw_c1", 32'(pat_a()), 32'(P_FRZ));
        @(negedge clk); lu_setup(ADD_X5_X7, 5'd5); redirect_ex = 1'b1; #1;
        chk("mw_c2_prio", 32'(pat_a()), 32'(P_FRZ));
        @(negedge clk); idle(); mem_op_mem = 1'b1; #1;
        chk("mw_c3", 32'(pat_a()), 32'(P_FRZ));
        chk("mw_c3_b", 32'(pat_b()), 32'(P_FRZ));
        @(negedge clk); dmem_ack = 1'b1; redirect_ex = 1'b1; #1;
        chk("mw_rel", 32'(pat_a()), 32'(P_RREL));
        @(negedge clk); idle(); #1;
        chk("mw_free", 32'(pat_a()), 32'(P_FREE));
        chk("mw_cnt", a_stall_cnt, 32'd6);

        @(negedge clk); idle(); mem_op_mem = 1'b1; dmem_ack = 1'b1; #1;
        chk("zero_wait", 32'(pat_a()), 32'(P_REL));
        @(negedge clk); idle(); #1;
        chk("zero_cnt", a_stall_cnt, 32'd6);

        // timeout on the MAX_WAIT=4 instance
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); idle(); mem_op_mem = 1'b1; #1;
            chk($sformatf("to_b_c%0d", i), 32'(pat_b()),
                32'((i == 4) ? P_TO : P_FRZ));
            if (i == 4)
                chk("to_a_c4", 32'(pat_a()), 32'(P_FRZ));
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_b", 32'(pat_b()), 32'(P_FREE));
        chk("async_rst_a", 32'(pat_a()), 32'(P_FREE));
        chk("async_rst_cnt", 32'(b_stall_cnt), 32'd0);

        @(negedge clk); idle(); rst_n = 1'b1; #1;
        chk("post_rst", 32'(pat_b()), 32'(P_FREE));

        // saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); idle(); imem_ready = 1'b0; #1;
            chk($sformatf("sat_flush_%0d", i), 32'(b_if_id_flush), 32'd1);
        end
        @(negedge clk); idle(); #1;
        chk("sat_cnt_b", 32'(b_stall_cnt), 32'd15);
        chk("sat_cnt_a", a_stall_cnt, 32'd20);
        @(negedge clk); idle(); imem_ready = 1'b0; #1;
        @(negedge clk); idle(); #1;
        chk("sat_hold_b", 32'(b_stall_cnt), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
